// File: rtl/mem_stage_dm.sv
// MIPS MEM stage: word-organised data RAM that merges sw/sh/sb stores, returns the raw word and flags bad addresses.
// Also publishes a registered store trace and a 16-bit count of committed stores.
module mem_stage_dm #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] wd_m,
    input  logic        dmwrm,
    input  logic [1:0]  dmwropm,
    input  logic [2:0]  dmrdopm,
    output logic [31:0] dm_rd_m,
    output logic        adel_m,
    output logic        ades_m,
    output logic        wr_vld,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [15:0] store_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           r_mem [DEPTH];
    logic                  r_wr_vld;
    logic [31:0]           r_wr_addr;
    logic [31:0]           r_wr_data;
    logic [15:0]           r_store_cnt;

    logic [32:0]           w_off33;
    logic [32:0]           w_word_off;
    logic [31:0]           w_off;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_in_range;
    logic                  w_st_mis;
    logic                  w_st_rsvd;
    logic                  w_is_load;
    logic                  w_ld_mis;
    logic [31:0]           w_old;
    logic [31:0]           w_merged;
    logic                  w_commit;

    // The 33-bit subtraction exposes addresses below BASE_ADDR through its top bit instead of wrapping.
    assign w_off33    = {1'b0, alu_result_m} - {1'b0, BASE_ADDR};
    assign w_word_off = w_off33 >> 2;
    assign w_off      = w_off33[31:0];
    assign w_idx      = w_off[ADDR_WIDTH+1:2];
    assign w_in_range = (alu_result_m >= BASE_ADDR) && (w_word_off < 33'(DEPTH));
    assign w_old      = r_mem[w_idx];

    // Store alignment by size; the reserved size is treated as a fault.
    always_comb begin
        w_st_mis  = 1'b0;
        w_st_rsvd = 1'b0;
        case (dmwropm)
            2'b00:   w_st_mis = (w_off[1:0] != 2'b00);
            2'b01:   w_st_mis = w_off[0];
            2'b10:   w_st_mis = 1'b0;
            default: w_st_rsvd = 1'b1;
        endcase
    end

    // Load alignment by type; codes above lbu are not loads.
    always_comb begin
        w_is_load = 1'b1;
        w_ld_mis  = 1'b0;
        case (dmrdopm)
            3'b000:          w_ld_mis = (w_off[1:0] != 2'b00);
            3'b001, 3'b010:  w_ld_mis = w_off[0];
            3'b011, 3'b100:  w_ld_mis = 1'b0;
            default:         w_is_load = 1'b0;
        endcase
    end

    assign ades_m   = reset & dmwrm & (~w_in_range | w_st_mis | w_st_rsvd);
    assign adel_m   = reset & w_is_load & (~w_in_range | w_ld_mis);
    assign w_commit = reset & dmwrm & ~ades_m;

    // Raw read port: reads the pre-store word during a same-cycle store.
    always_comb begin
        if (w_in_range) begin
            dm_rd_m = w_old;
        end else begin
            dm_rd_m = 32'h0000_0000;
        end
    end

    // Merge store data into the addressed word, leaving untouched lanes intact.
    always_comb begin
        w_merged = w_old;
        case (dmwropm)
            2'b00: w_merged = wd_m;
            2'b01: begin
                if (w_off[1]) begin
                    w_merged[31:16] = wd_m[15:0];
                end else begin
                    w_merged[15:0] = wd_m[15:0];
                end
            end
            2'b10: begin
                case (w_off[1:0])
                    2'b00:   w_merged[7:0]   = wd_m[7:0];
                    2'b01:   w_merged[15:8]  = wd_m[7:0];
                    2'b10:   w_merged[23:16] = wd_m[7:0];
                    default: w_merged[31:24] = wd_m[7:0];
                endcase
            end
            default: w_merged = w_old;
        endcase
    end

    // RAM array: cleared on reset, written only by a committed store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i[ADDR_WIDTH-1:0]] <= 32'h0000_0000;
            end
        end else if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Store trace and commit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_vld    <= 1'b0;
            r_wr_addr   <= 32'h0000_0000;
            r_wr_data   <= 32'h0000_0000;
            r_store_cnt <= 16'h0000;
        end else begin
            r_wr_vld <= w_commit;
            if (w_commit) begin
                r_wr_addr   <= BASE_ADDR + 32'({w_idx, 2'b00});
                r_wr_data   <= w_merged;
                r_store_cnt <= r_store_cnt + 16'h0001;
            end
        end
    end

    assign wr_vld    = r_wr_vld;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign store_cnt = r_store_cnt;

endmodule

// File: doc/mem_stage_dm.md
Name: mem_stage_dm

Overview:
- Data-memory stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Takes the EX/MEM ALU result as the address and performs word, halfword and byte stores into a word-organised RAM.
- Returns the raw addressed word as dm_rd_m. Load extension is done in WB using dmrdop, so this block never extends data.
- Flags misaligned and out-of-range accesses. Publishes a registered store trace and a store counter for the testbench.

Parameters:
- ADDR_WIDTH, 10, log2 of RAM depth in words (1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk, input, 1, pipeline clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; 0 clears all state immediately.
- alu_result_m, input, 32, byte address of the access.
- wd_m, input, 32, store data from the forwarded rt value.
- dmwrm, input, 1, store request this cycle.
- dmwropm, input, 2, store size: 00 sw, 01 sh, 10 sb, 11 reserved.
- dmrdopm, input, 3, load type, used only for the alignment check: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others mean no load.
- dm_rd_m, output, 32, raw word at the addressed index (combinational).
- adel_m, output, 1, load address fault (combinational).
- ades_m, output, 1, store address fault (combinational).
- wr_vld, output, 1, registered: a store committed on the previous edge.
- wr_addr, output, 32, registered: word-aligned byte address of the last committed store.
- wr_data, output, 32, registered: full merged word written by that store.
- store_cnt, output, 16, registered count of committed stores.

Behaviour:
- Definitions:
  - off = alu_result_m - BASE_ADDR.
  - idx = off[ADDR_WIDTH+1:2].
  - in_range = (alu_result_m >= BASE_ADDR) and (off >> 2) < 2^ADDR_WIDTH, computed in 33 bits so there is no wrap.
- Alignment:
  - sw and lw need off[1:0]==0.
  - sh, lh and lhu need off[0]==0.
  - Byte accesses are always aligned.
- ades_m = dmwrm and (not in_range, or misaligned, or dmwropm==11).
- adel_m = (dmrdopm is in 000..100) and (not in_range, or misaligned). Both are 0 while reset is asserted.
- Read path:
  - dm_rd_m = mem[idx] when in_range, otherwise 32'h0. It is purely combinational, with zero cycles of latency.
  - On a simultaneous read and store to the same word, dm_rd_m shows the pre-store contents in that cycle. The new contents appear after the edge.
- Store commit happens on posedge clk when reset=1, dmwrm=1 and ades_m=0:
  - sw writes all 32 bits with wd_m.
  - sh writes wd_m[15:0] into lane [15:0] if off[1]==0, otherwise into [31:16].
  - sb writes wd_m[7:0] into lane 8*off[1:0]+:8.
  - Lanes that are not written keep their old value.
  - A faulting store changes no memory word.
- Trace registers are updated every edge:
  - wr_vld <= commit.
  - When commit=1, wr_addr <= BASE_ADDR + {idx,2'b00} and wr_data <= the merged word. Otherwise both hold their values.
- store_cnt increments by 1 on each commit and wraps from 16'hFFFF to 16'h0000.
- Reset (reset==0, async):
  - All RAM words are set to 0.
  - wr_vld, wr_addr, wr_data and store_cnt are set to 0.
  - Inputs are ignored while reset is low.
  - A store presented on the same edge as reset release does commit. Reset deassertion is synchronised outside this block.
  - Reset asserted mid-stream discards everything, with no partial writes.
- There are no stall or backpressure inputs. The stage is single-cycle, and the upstream register holds inputs when the pipeline stalls.
- With dmwrm=0, no state changes except wr_vld <= 0.

Test Plan:
- Reset low, then high. Read addresses 0x0, 0x4 and 0xFFC → dm_rd_m=0. wr_vld=0, store_cnt=0.
- sw 0x11223344 to 0x10, then sh 0xAABB to 0x12, then sb 0xCC to 0x11 → read 0x10 returns 0xAABBCC44. store_cnt=3. Final wr_addr=0x10, wr_data=0xAABBCC44.
- Misaligned accesses:
  - sw to 0x22 → ades_m=1, word 0x20 unchanged, store_cnt unchanged, wr_vld=0.
  - lh at 0x23 → adel_m=1.
  - lb at 0x23 → adel_m=0.
- Out of range with ADDR_WIDTH=10:
  - sw 0xDEADBEEF to 0x1000 → ades_m=1, no write, word 0 still 0.
  - lw at 0x1000 → dm_rd_m=0, adel_m=1.
- Same-cycle read/write: sw 0x5 to 0x40 while reading 0x40 (old value 0x0) → dm_rd_m=0 in that cycle, 0x5 the next cycle. wr_vld=1 for exactly one cycle.
- Async reset mid-stream:
  - Drop reset between edges after several stores → all outputs go to 0 immediately and word 0x10 reads 0.
  - Preload store_cnt to 16'hFFFF via 65535 stores; one more store → store_cnt=0.
